mem_port_ctrl: RTL and testbench

- Memory-side port controller sitting directly downstream of the data cache, between the cache's miss/write-through path and the 4-byte-lane main memory.
- Accepts one word request at a time from the cache over a valid/ready handshake.
- Holds address, data and write-enable stable for the fixed memory latency.
- Packs and unpacks big-endian byte lanes, returns read data with a one-cycle response strobe, and posts writes through a one-entry write buffer so cache writes are acknowledged without a 4-cycle stall.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/mem_port_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the cache-to-memory port.
package mem_pkg;

  localparam int unsigned MEM_LATENCY_DEFAULT = 4;
  localparam int unsigned ADDR_W_DEFAULT      = 32;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned LANE_W              = 8;
  localparam int unsigned NUM_LANES           = 4;
  localparam int unsigned CNT_W               = 4;

  // Lane 0 carries the most significant byte (big-endian memory).
  typedef logic [0:NUM_LANES-1][LANE_W-1:0] byte_lanes_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_DRAIN = 2'd1,
    RD_WAIT  = 2'd2,
    RD_RESP  = 2'd3
  } mem_state_e;

  function automatic byte_lanes_t word_to_lanes(input logic [WORD_W-1:0] w);
    byte_lanes_t l;
    l[0] = w[31:24];
    l[1] = w[23:16];
    l[2] = w[15:8];
    l[3] = w[7:0];
    return l;
  endfunction

  function automatic logic [WORD_W-1:0] lanes_to_word(input byte_lanes_t l);
    return {l[0], l[1], l[2], l[3]};
  endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// Memory-side port controller: one request at a time, fixed memory latency,
// posted writes through a one-entry buffer, big-endian byte lanes.
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT,
  parameter int unsigned ADDR_W      = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output byte_lanes_t       mem_data_in,
  input  byte_lanes_t       mem_data_out,
  output logic              mem_write_en,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_W-1:0] wb_data_q, wb_data_d;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [WORD_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  byte_lanes_t       mem_data_in_q, mem_data_in_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic              busy_q, busy_d;

  logic              accept_c;
  logic              last_c;
  logic [ADDR_W-1:0] aligned_addr_c;
  logic              addr_lsb_unused;

  assign accept_c        = req_valid && req_ready_q;
  assign last_c          = (cnt_q == CNT_LAST);
  assign aligned_addr_c  = {req_addr[ADDR_W-1:2], 2'b00};
  assign addr_lsb_unused = |req_addr[1:0];

  // State, buffer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wb_valid_q     <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      req_ready_q    <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_data_in_q  <= '0;
      mem_write_en_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wb_valid_q     <= wb_valid_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_in_q  <= mem_data_in_d;
      mem_write_en_q <= mem_write_en_d;
      busy_q         <= busy_d;
    end
  end

  // Next state, latency counter and write buffer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      WR_DRAIN: begin
        if (last_c) begin
          state_d    = IDLE;
          wb_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_WAIT: begin
        if (last_c) begin
          state_d = RD_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance only happens when idle or on the final drain edge.
    if (accept_c) begin
      cnt_d = '0;
      if (req_write) begin
        state_d    = WR_DRAIN;
        wb_valid_d = 1'b1;
        wb_addr_d  = aligned_addr_c;
        wb_data_d  = req_wdata;
      end else begin
        state_d = RD_WAIT;
      end
    end
  end

  // Output values for the cycle after this edge.
  always_comb begin
    req_ready_d    = (state_d == IDLE) || ((state_d == WR_DRAIN) && (cnt_d == CNT_LAST));
    busy_d         = (state_d != IDLE);
    resp_valid_d   = (state_d == RD_RESP);
    mem_write_en_d = wb_valid_d;
    mem_addr_d     = mem_addr_q;
    mem_data_in_d  = mem_data_in_q;
    resp_rdata_d   = resp_rdata_q;

    if (wb_valid_d) begin
      mem_addr_d    = wb_addr_d;
      mem_data_in_d = word_to_lanes(wb_data_d);
    end else if (accept_c) begin
      mem_addr_d = aligned_addr_c;
    end

    if ((state_q == RD_WAIT) && last_c) begin
      resp_rdata_d = lanes_to_word(mem_data_out);
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_write_en = mem_write_en_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: one instance at latency 4, one at latency 1,
// each with a simple memory that commits a write after a full latency of strobe.
module tb_mem_port_ctrl;
  import mem_pkg::*;

  localparam int L0 = 4;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic req_valid, req_write;
  logic [31:0] req_addr, req_wdata;

  logic rv0, rdy0, rspv0, we0, busy0;
  logic [31:0] rdata0, addr0;
  byte_lanes_t din0, dout0;
  logic rv1, rdy1, rspv1, we1, busy1;
  logic [31:0] rdata1, addr1;
  byte_lanes_t din1, dout1;

  logic rdy_m, rspv_m, we_m, busy_m;
  logic [31:0] rdata_m, addr_m;
  byte_lanes_t lanes_m;

  int n_cmp = 0;
  int n_fail = 0;
  bit [31:0] ref_mem [2][256];
  bit [31:0] mem0 [256];
  bit [31:0] mem1 [256];
  int run0 = 0;
  int run1 = 0;

  always #5 clk = ~clk;

  assign rv0 = req_valid & ~sel;
  assign rv1 = req_valid & sel;

  mem_port_ctrl #(.MEM_LATENCY(L0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .reset(rst_n), .req_valid(rv0), .req_ready(rdy0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rspv0), .resp_rdata(rdata0),
    .mem_addr(addr0), .mem_data_in(din0), .mem_data_out(dout0), .mem_write_en(we0),
    .busy(busy0));

  mem_port_ctrl #(.MEM_LATENCY(L1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .reset(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rspv1), .resp_rdata(rdata1),
    .mem_addr(addr1), .mem_data_in(din1), .mem_data_out(dout1), .mem_write_en(we1),
    .busy(busy1));

  assign rdy_m   = sel ? rdy1   : rdy0;
  assign rspv_m  = sel ? rspv1  : rspv0;
  assign we_m    = sel ? we1    : we0;
  assign busy_m  = sel ? busy1  : busy0;
  assign rdata_m = sel ? rdata1 : rdata0;
  assign addr_m  = sel ? addr1  : addr0;
  assign lanes_m = sel ? din1   : din0;

  // Memory models: a write lands only after the strobe is held a full latency.
  always @(posedge clk) begin
    if (we0) begin
      if (run0 + 1 >= L0) begin
        mem0[addr0[9:2]] <= {din0[0], din0[1], din0[2], din0[3]};
        run0 <= 0;
      end else run0 <= run0 + 1;
    end else run0 <= 0;
    if (we1) begin
      if (run1 + 1 >= L1) begin
        mem1[addr1[9:2]] <= {din1[0], din1[1], din1[2], din1[3]};
        run1 <= 0;
      end else run1 <= run1 + 1;
    end else run1 <= 0;
  end

  always @(negedge clk) begin
    dout0 <= {mem0[addr0[9:2]][31:24], mem0[addr0[9:2]][23:16], mem0[addr0[9:2]][15:8], mem0[addr0[9:2]][7:0]};
    dout1 <= {mem1[addr1[9:2]][31:24], mem1[addr1[9:2]][23:16], mem1[addr1[9:2]][15:8], mem1[addr1[9:2]][7:0]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and wait (bounded) until it is accepted; returns at the first cycle after acceptance.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit hold, output int waited);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waited = 0;
    while (!rdy_m && waited < 40) begin
      step();
      waited++;
    end
    n_cmp++;
    if (!rdy_m) begin
      n_fail++;
      $display("FAIL accept_timeout: req_ready got %b after %0d cycles, required 1", rdy_m, waited);
    end
    step();
    if (!hold) begin
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    if (wr) ref_mem[sel][addr[9:2]] = wdata;
  endtask

  // Write drain: strobe, address and lanes held for the full latency, ready only on the last cycle.
  task automatic check_write(input logic [31:0] addr, input logic [31:0] wdata);
    int l = sel ? L1 : L0;
    logic [3:0] exp_f;
    logic [31:0] ea = addr & 32'hFFFF_FFFC;
    for (int k = 0; k < l; k++) begin
      if (k > 0) step();
      exp_f = {1'b1, 1'b0, 1'b1, 1'(k == l - 1)};
      n_cmp++;
      if ({we_m, rspv_m, busy_m, rdy_m} !== exp_f) begin
        n_fail++;
        $display("FAIL wr_flags k=%0d: we/rv/busy/rdy got %b required %b", k, {we_m, rspv_m, busy_m, rdy_m}, exp_f);
      end
      n_cmp++;
      if (addr_m !== ea) begin
        n_fail++;
        $display("FAIL wr_addr k=%0d: got %h required %h", k, addr_m, ea);
      end
      n_cmp++;
      if (lanes_m[0] !== wdata[31:24] || lanes_m[1] !== wdata[23:16] ||
          lanes_m[2] !== wdata[15:8]  || lanes_m[3] !== wdata[7:0]) begin
        n_fail++;
        $display("FAIL wr_lanes k=%0d: got %h %h %h %h required word %h", k,
                 lanes_m[0], lanes_m[1], lanes_m[2], lanes_m[3], wdata);
      end
    end
  endtask

  // Read: wait for the latency, one-cycle response strobe, then idle. A dropped unaccepted request is injected.
  task automatic check_read(input logic [31:0] addr, input logic [31:0] exp_data);
    int l = sel ? L1 : L0;
    logic [3:0] exp_f;
    logic [31:0] ea = addr & 32'hFFFF_FFFC;
    for (int k = 0; k <= l + 1; k++) begin
      if (k > 0) step();
      exp_f = {1'b0, 1'(k == l), 1'(k <= l), 1'(k == l + 1)};
      n_cmp++;
      if ({we_m, rspv_m, busy_m, rdy_m} !== exp_f) begin
        n_fail++;
        $display("FAIL rd_flags k=%0d: we/rv/busy/rdy got %b required %b", k, {we_m, rspv_m, busy_m, rdy_m}, exp_f);
      end
      if (k <= l) begin
        n_cmp++;
        if (addr_m !== ea) begin
          n_fail++;
          $display("FAIL rd_addr k=%0d: got %h required %h", k, addr_m, ea);
        end
      end
      if (k >= l) begin
        n_cmp++;
        if (rdata_m !== exp_data) begin
          n_fail++;
          $display("FAIL rd_data k=%0d: got %h required %h", k, rdata_m, exp_data);
        end
      end
      if (k == 0) begin
        req_valid = 1'b1;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      if (k == 1) req_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) step();
    n_cmp++;
    if ({rdy0, rspv0, rdata0, addr0, din0, we0, busy0, rdy1, rspv1, rdata1, addr1, din1, we1, busy1} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h %h required all zero",
               {rdy0, rspv0, rdata0, addr0, din0, we0, busy0}, {rdy1, rspv1, rdata1, addr1, din1, we1, busy1});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({rdy0, busy0, rdy1, busy1} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reset_release: rdy0/busy0/rdy1/busy1 got %b required 1010", {rdy0, busy0, rdy1, busy1});
    end
  endtask

  task automatic test_single_read();
    int w;
    sel = 1'b0;
    issue(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, w);
    check_write(32'h40, 32'hDEADBEEF);
    step();
    issue(1'b0, 32'h40, 32'h0, 1'b0, w);
    check_read(32'h40, 32'hDEADBEEF);
  endtask

  task automatic test_posted_write();
    int w;
    sel = 1'b0;
    issue(1'b1, 32'h104, 32'h12345678, 1'b0, w);
    n_cmp++;
    if ({lanes_m[0], lanes_m[1], lanes_m[2], lanes_m[3]} !== {8'h12, 8'h34, 8'h56, 8'h78}) begin
      n_fail++;
      $display("FAIL posted_lanes: got %h %h %h %h required 12 34 56 78", lanes_m[0], lanes_m[1], lanes_m[2], lanes_m[3]);
    end
    check_write(32'h104, 32'h12345678);
    step();
    n_cmp++;
    if ({we_m, rspv_m, busy_m, rdy_m} !== 4'b0001) begin
      n_fail++;
      $display("FAIL posted_idle: we/rv/busy/rdy got %b required 0001", {we_m, rspv_m, busy_m, rdy_m});
    end
  endtask

  task automatic test_unaligned();
    int w;
    sel = 1'b0;
    issue(1'b0, 32'h43, 32'h0, 1'b0, w);
    n_cmp++;
    if (addr_m !== 32'h40) begin
      n_fail++;
      $display("FAIL unaligned_addr: got %h required 00000040", addr_m);
    end
    check_read(32'h43, 32'hDEADBEEF);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] wd = $urandom;
    sel = 1'b0;
    issue(1'b1, 32'h8, wd, 1'b1, w);
    check_write(32'h8, wd);
    issue(1'b0, 32'h8, 32'h0, 1'b0, w);
    n_cmp++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL b2b_bubble: waited %0d cycles, required 0", w);
    end
    check_read(32'h8, wd);
  endtask

  task automatic test_reset_mid_write();
    int w;
    sel = 1'b0;
    issue(1'b1, 32'h200, 32'hA5A50001, 1'b0, w);
    check_write(32'h200, 32'hA5A50001);
    step();
    issue(1'b1, 32'h200, 32'hFFFF0000, 1'b0, w);
    ref_mem[0][8'h80] = 32'hA5A50001;
    n_cmp++;
    if (we_m !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: we got %b required 1", we_m);
    end
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdy0, rspv0, rdata0, addr0, din0, we0, busy0} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h required all zero", {rdy0, rspv0, rdata0, addr0, din0, we0, busy0});
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (rdy_m !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b required 1", rdy_m);
    end
    issue(1'b0, 32'h200, 32'h0, 1'b0, w);
    check_read(32'h200, 32'hA5A50001);
  endtask

  task automatic test_latency1();
    int w;
    logic [31:0] wd = $urandom;
    sel = 1'b1;
    issue(1'b1, 32'h40, wd, 1'b1, w);
    check_write(32'h40, wd);
    issue(1'b0, 32'h40, 32'h0, 1'b0, w);
    n_cmp++;
    if (w != 0) begin
      n_fail++;
      $display("FAIL lat1_bubble: waited %0d cycles, required 0", w);
    end
    check_read(32'h40, wd);
    issue(1'b1, 32'h44, ~wd, 1'b0, w);
    check_write(32'h44, ~wd);
    step();
    n_cmp++;
    if ({we_m, rspv_m, busy_m, rdy_m} !== 4'b0001) begin
      n_fail++;
      $display("FAIL lat1_idle: we/rv/busy/rdy got %b required 0001", {we_m, rspv_m, busy_m, rdy_m});
    end
  endtask

  task automatic test_random(input bit s, input int n);
    bit wr, hold, prev_hold;
    int w, idx;
    logic [31:0] addr, wd;
    sel = s;
    prev_hold = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr   = 1'($urandom);
      idx  = int'($urandom_range(0, 15));
      addr = 32'h300 + 32'(idx * 4) + $urandom_range(0, 3);
      wd   = $urandom;
      hold = wr && (i != n - 1) && 1'($urandom);
      issue(wr, addr, wd, hold, w);
      if (prev_hold) begin
        n_cmp++;
        if (w != 0) begin
          n_fail++;
          $display("FAIL rand_b2b i=%0d: waited %0d cycles, required 0", i, w);
        end
      end
      if (wr) check_write(addr, wd);
      else check_read(addr, ref_mem[sel][addr[9:2]]);
      if (wr && !hold) step();
      if (!hold) begin
        repeat ($urandom_range(0, 2)) step();
        n_cmp++;
        if ({we_m, rspv_m, busy_m, rdy_m} !== 4'b0001) begin
          n_fail++;
          $display("FAIL rand_idle i=%0d: we/rv/busy/rdy got %b required 0001", i, {we_m, rspv_m, busy_m, rdy_m});
        end
      end
      prev_hold = hold;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_posted_write();
    test_unaligned();
    test_back_to_back();
    test_reset_mid_write();
    test_random(1'b0, 40);
    test_latency1();
    test_random(1'b1, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
